// File: rtl/random_delay_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : random_delay_gen_if
// Brief   : Control/status bundle for the pseudo-random delay generator.
//           The master drives start/abort/seed loading and observes the
//           busy/done handshake and the chosen delay.
// Revision: 1.0 - initial release
// ============================================================================
interface random_delay_gen_if #(
  parameter int LFSR_WIDTH = 8,
  parameter int UNIT_W     = 4
);
  logic                  start;
  logic                  abort;
  logic                  seed_load;
  logic [LFSR_WIDTH-1:0] seed_in;
  logic                  busy;
  logic                  done;
  logic [UNIT_W-1:0]     delay_units;

  modport master (
    output start, abort, seed_load, seed_in,
    input  busy, done, delay_units
  );

  modport slave (
    input  start, abort, seed_load, seed_in,
    output busy, done, delay_units
  );
endinterface
`default_nettype wire

// File: rtl/random_delay_gen.sv
`default_nettype none
// ============================================================================
// Module  : random_delay_gen
// Brief   : Free-running LFSR sampled on start, folded into the range
//           [MIN_UNITS, MAX_UNITS]; the block then counts that many units of
//           TICKS_PER_UNIT clocks and pulses done. Supports seed loading,
//           abort, and one-shot or periodic re-arming.
// Revision: 1.0 - initial release
// ============================================================================
module random_delay_gen #(
  parameter int                    LFSR_WIDTH     = 8,
  parameter logic [LFSR_WIDTH-1:0] TAPS           = 8'b1011_1000,
  parameter logic [LFSR_WIDTH-1:0] SEED           = LFSR_WIDTH'(1),
  parameter int                    MIN_UNITS      = 2,
  parameter int                    MAX_UNITS      = 15,
  parameter int                    TICKS_PER_UNIT = 100_000_000,
  parameter bit                    PERIODIC       = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  random_delay_gen_if.slave  bus
);

  localparam int UNIT_W  = $clog2(MAX_UNITS + 1);
  localparam int c_range = MAX_UNITS - MIN_UNITS + 1;
  // Width of the raw slice taken from the LFSR; raw < 2*c_range by construction.
  localparam int c_rw    = (c_range > 1) ? $clog2(c_range) : 1;
  localparam int c_pw    = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;

  // One extra bit so that c_range itself is representable when it is a power of two.
  localparam logic [c_rw:0]     c_range_v    = (c_rw + 1)'(c_range);
  localparam logic [c_pw-1:0]   c_presc_last = c_pw'(TICKS_PER_UNIT - 1);
  localparam logic [UNIT_W-1:0] c_min_units  = UNIT_W'(MIN_UNITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [LFSR_WIDTH-1:0] r_lfsr;
  logic [c_pw-1:0]       r_presc;
  logic [UNIT_W-1:0]     r_unit_cnt;
  logic [UNIT_W-1:0]     r_delay_units;

  logic [LFSR_WIDTH-1:0] w_lfsr_step;
  logic [LFSR_WIDTH-1:0] w_seed;
  logic [c_rw:0]         w_raw;
  logic [c_rw:0]         w_mapped;
  logic [UNIT_W-1:0]     w_units;
  logic                  w_wrap;
  logic                  w_last_unit;
  logic                  w_load;
  logic                  w_clear;
  logic                  w_busy;
  logic                  w_done;

  assign w_lfsr_step = {r_lfsr[LFSR_WIDTH-2:0], ^(r_lfsr & TAPS)};
  // A zero seed would lock the LFSR, so it is promoted to 1.
  assign w_seed      = (bus.seed_in == '0) ? LFSR_WIDTH'(1) : bus.seed_in;

  // Fold the raw slice into [0, c_range) with one conditional subtract.
  assign w_raw       = {1'b0, r_lfsr[c_rw-1:0]};
  assign w_mapped    = (w_raw >= c_range_v) ? (w_raw - c_range_v) : w_raw;
  assign w_units     = c_min_units + UNIT_W'(w_mapped);

  assign w_wrap      = (r_presc == c_presc_last);
  assign w_last_unit = (r_unit_cnt == UNIT_W'(1));

  // LFSR free-runs in every state; a seed load takes precedence over stepping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= SEED;
    end else if (bus.seed_load) begin
      r_lfsr <= w_seed;
    end else begin
      r_lfsr <= w_lfsr_step;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus counter load/clear strobes and status outputs.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          w_state_next = ST_COUNT;
          w_load       = 1'b1;
        end
      end
      ST_COUNT: begin
        w_busy = 1'b1;
        if (bus.abort) begin
          w_state_next = ST_IDLE;
          w_clear      = 1'b1;
        end else if (w_wrap && w_last_unit) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done = 1'b1;
        if (bus.abort) begin
          w_state_next = ST_IDLE;
          w_clear      = 1'b1;
        end else if (PERIODIC) begin
          w_state_next = ST_COUNT;
          w_load       = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_clear      = 1'b1;
      end
    endcase
  end

  // Prescaler, unit counter and captured delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc       <= '0;
      r_unit_cnt    <= '0;
      r_delay_units <= '0;
    end else if (w_load) begin
      r_presc       <= '0;
      r_unit_cnt    <= w_units;
      r_delay_units <= w_units;
    end else if (w_clear) begin
      r_presc       <= '0;
      r_unit_cnt    <= '0;
    end else if (r_state == ST_COUNT) begin
      if (w_wrap) begin
        r_presc    <= '0;
        r_unit_cnt <= r_unit_cnt - UNIT_W'(1);
      end else begin
        r_presc    <= r_presc + c_pw'(1);
      end
    end
  end

  // Status is decoded from the state register so reset drops it at once.
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.delay_units = r_delay_units;

endmodule
`default_nettype wire
